// File: rtl/apb_event_slave.sv
// ----------------------------------------------------------------------------
// apb_event_slave
//   APB completer for the event-to-APB master. It holds three 32-bit event
//   mailboxes (EVT_A/B/C) and a saturating write counter for each mailbox.
//   Every committed mailbox write produces a one-cycle event strobe.
//   A programmable number of wait states is inserted before PREADY.
//   Unmapped addresses are answered with PSLVERR.
//
// Ports
//   clk, rst            clock (posedge), asynchronous active-low reset
//   psel_i, penable_i   APB select / access-phase enable
//   paddr_i, pwrite_i   full 32-bit address, 1 = write
//   pwdata_i            write data
//   pready_o            transfer complete (one cycle, from the state register)
//   prdata_o            read data, zero unless pready_o=1 on a read
//   pslverr_o           unmapped access, valid only with pready_o
//   evt_a/b/c_o         one-cycle pulse after a committed write to EVT_A/B/C
// ----------------------------------------------------------------------------
module apb_event_slave #(
    parameter int WAIT_CYCLES = 1,   // 0..15
    parameter int CNT_W       = 8    // 1..10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic [31:0] paddr_i,
    input  logic        pwrite_i,
    input  logic [31:0] pwdata_i,
    output logic        pready_o,
    output logic [31:0] prdata_o,
    output logic        pslverr_o,
    output logic        evt_a_o,
    output logic        evt_b_o,
    output logic        evt_c_o
);

    localparam logic [31:0] ADDR_EVT_A = 32'h1000_1000;
    localparam logic [31:0] ADDR_EVT_B = 32'h2000_2000;
    localparam logic [31:0] ADDR_EVT_C = 32'h3000_3000;
    localparam logic [31:0] ADDR_CNT   = 32'h4000_0000;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t           state, state_nxt;
    logic [3:0]       wcnt, wcnt_nxt;
    logic [31:0]      evt_a_q, evt_b_q, evt_c_q;
    logic [CNT_W-1:0] cnt_a, cnt_b, cnt_c;
    logic [31:0]      cnt_word;
    logic             sel_a, sel_b, sel_c, sel_cnt, mapped;
    logic             commit;

    // ------------------------------------------------------------------
    // Transfer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            wcnt  <= 4'd0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            IDLE: begin
                // Only a setup phase starts a transfer; a stray penable
                // without a fresh setup is ignored.
                if (psel_i && !penable_i) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = WAIT;
                        wcnt_nxt  = 4'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                if (!psel_i) begin
                    state_nxt = IDLE;
                    wcnt_nxt  = 4'd0;
                end else if (penable_i) begin
                    wcnt_nxt = wcnt - 4'd1;
                    if (wcnt == 4'd1) state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                wcnt_nxt  = 4'd0;
            end
            default: begin
                state_nxt = IDLE;
                wcnt_nxt  = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address decode and response
    // ------------------------------------------------------------------
    assign sel_a   = (paddr_i == ADDR_EVT_A);
    assign sel_b   = (paddr_i == ADDR_EVT_B);
    assign sel_c   = (paddr_i == ADDR_EVT_C);
    assign sel_cnt = (paddr_i == ADDR_CNT);
    assign mapped  = sel_a | sel_b | sel_c | sel_cnt;

    // A write lands only if the master is still in the access phase when
    // DONE ends; dropping psel_i there aborts without side effects.
    assign commit = (state == DONE) && psel_i && penable_i && pwrite_i && mapped;

    // pready_o comes straight from the state flops, so it is glitch-free.
    assign pready_o = (state == DONE);

    always_comb begin
        cnt_word = 32'd0;
        cnt_word[3*CNT_W-1:0] = {cnt_c, cnt_b, cnt_a};
    end

    always_comb begin
        prdata_o  = 32'd0;
        pslverr_o = 1'b0;
        if (state == DONE) begin
            pslverr_o = !mapped;
            if (!pwrite_i) begin
                if (sel_a)   prdata_o = evt_a_q;
                if (sel_b)   prdata_o = evt_b_q;
                if (sel_c)   prdata_o = evt_c_q;
                if (sel_cnt) prdata_o = cnt_word;
            end
        end
    end

    // ------------------------------------------------------------------
    // Mailboxes, counters and event strobes
    // ------------------------------------------------------------------
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evt_a_q <= 32'd0;
            evt_b_q <= 32'd0;
            evt_c_q <= 32'd0;
            cnt_a   <= '0;
            cnt_b   <= '0;
            cnt_c   <= '0;
            evt_a_o <= 1'b0;
            evt_b_o <= 1'b0;
            evt_c_o <= 1'b0;
        end else begin
            // Strobes fire in the cycle after the commit edge, also when
            // the counter is already saturated.
            evt_a_o <= commit && sel_a;
            evt_b_o <= commit && sel_b;
            evt_c_o <= commit && sel_c;
            if (commit) begin
                if (sel_a) begin
                    evt_a_q <= pwdata_i;
                    cnt_a   <= sat_inc(cnt_a);
                end
                if (sel_b) begin
                    evt_b_q <= pwdata_i;
                    cnt_b   <= sat_inc(cnt_b);
                end
                if (sel_c) begin
                    evt_c_q <= pwdata_i;
                    cnt_c   <= sat_inc(cnt_c);
                end
                if (sel_cnt) begin
                    cnt_a <= '0;
                    cnt_b <= '0;
                    cnt_c <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_event_slave.sv
// ----------------------------------------------------------------------------
// tb_apb_event_slave
//   Three instances share clk/rst and the APB address/data/enable lines,
//   each with its own psel: WAIT_CYCLES = 1, 0 and 3. A reference model of
//   the mailboxes and counters produces the expected response of every
//   transfer; it is queued when the setup is driven and compared when the
//   DUT raises pready_o. Event strobes are counted on every clock.
// ----------------------------------------------------------------------------
module tb_apb_event_slave;

    localparam logic [31:0] A_EVT_A = 32'h1000_1000;
    localparam logic [31:0] A_EVT_B = 32'h2000_2000;
    localparam logic [31:0] A_EVT_C = 32'h3000_3000;
    localparam logic [31:0] A_CNT   = 32'h4000_0000;
    localparam logic [31:0] A_BAD   = 32'h5000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  psel = 3'b000;
    logic        penable = 1'b0;
    logic [31:0] paddr = 32'd0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = 32'd0;
    logic [2:0]  pready, pslverr, evt_a, evt_b, evt_c;
    logic [31:0] prdata [3];

    int errors = 0;
    int checks = 0;

    int wc[3] = '{1, 0, 3};

    // reference model
    logic [31:0] ma[3], mb[3], mc[3];
    logic [7:0]  mca[3], mcb[3], mcc[3];
    int          epa[3], epb[3], epc[3];
    int          pa[3], pb[3], pc[3];

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    apb_event_slave #(.WAIT_CYCLES(1), .CNT_W(8)) u_w1 (
        .clk(clk), .rst(rst), .psel_i(psel[0]), .penable_i(penable),
        .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata),
        .pready_o(pready[0]), .prdata_o(prdata[0]), .pslverr_o(pslverr[0]),
        .evt_a_o(evt_a[0]), .evt_b_o(evt_b[0]), .evt_c_o(evt_c[0]));

    apb_event_slave #(.WAIT_CYCLES(0), .CNT_W(8)) u_w0 (
        .clk(clk), .rst(rst), .psel_i(psel[1]), .penable_i(penable),
        .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata),
        .pready_o(pready[1]), .prdata_o(prdata[1]), .pslverr_o(pslverr[1]),
        .evt_a_o(evt_a[1]), .evt_b_o(evt_b[1]), .evt_c_o(evt_c[1]));

    apb_event_slave #(.WAIT_CYCLES(3), .CNT_W(8)) u_w3 (
        .clk(clk), .rst(rst), .psel_i(psel[2]), .penable_i(penable),
        .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata),
        .pready_o(pready[2]), .prdata_o(prdata[2]), .pslverr_o(pslverr[2]),
        .evt_a_o(evt_a[2]), .evt_b_o(evt_b[2]), .evt_c_o(evt_c[2]));

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (evt_a[k]) pa[k] <= pa[k] + 1;
            if (evt_b[k]) pb[k] <= pb[k] + 1;
            if (evt_c[k]) pc[k] <= pc[k] + 1;
        end
    end

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            ma[k] = 0; mb[k] = 0; mc[k] = 0;
            mca[k] = 0; mcb[k] = 0; mcc[k] = 0;
        end
    endtask

    // One full transfer on instance k. Returns at the negedge of the
    // completing cycle with psel still high, so the commit edge follows and
    // a subsequent xfer starts its setup right after DONE.
    task automatic xfer(input int k, input logic [31:0] a, input logic w,
                        input logic [31:0] d, input string nm);
        exp_t e;
        int   n;
        e.lat = wc[k] + 1;
        e.err = 1'b0;
        e.rd  = 32'd0;
        case (a)
            A_EVT_A: if (w) begin ma[k] = d; if (mca[k] != 8'hFF) mca[k]++; epa[k]++; end
                     else e.rd = ma[k];
            A_EVT_B: if (w) begin mb[k] = d; if (mcb[k] != 8'hFF) mcb[k]++; epb[k]++; end
                     else e.rd = mb[k];
            A_EVT_C: if (w) begin mc[k] = d; if (mcc[k] != 8'hFF) mcc[k]++; epc[k]++; end
                     else e.rd = mc[k];
            A_CNT:   if (w) begin mca[k] = 0; mcb[k] = 0; mcc[k] = 0; end
                     else e.rd = {8'h00, mcc[k], mcb[k], mca[k]};
            default: e.err = 1'b1;
        endcase
        sbq.push_back(e);
        @(negedge clk);
        psel = 3'b000; psel[k] = 1'b1; penable = 1'b0;
        paddr = a; pwrite = w; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        n = 1;
        while (pready[k] !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        e = sbq.pop_front();
        checks++;
        if (pready[k] !== 1'b1 || n != e.lat) begin
            errors++;
            $display("FAIL %s latency: inst=%0d got %0d cycles (pready=%b), expected %0d",
                     nm, k, n, pready[k], e.lat);
        end
        checks++;
        if (prdata[k] !== e.rd || pslverr[k] !== e.err) begin
            errors++;
            $display("FAIL %s response: inst=%0d prdata=%h pslverr=%b, expected prdata=%h pslverr=%b",
                     nm, k, prdata[k], pslverr[k], e.rd, e.err);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        psel = 3'b000; penable = 1'b0; paddr = 32'd0; pwrite = 1'b0; pwdata = 32'd0;
    endtask

    task automatic check_quiet(input string nm);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (pready[k] !== 1'b0 || prdata[k] !== 32'd0 || pslverr[k] !== 1'b0 ||
                evt_a[k] !== 1'b0 || evt_b[k] !== 1'b0 || evt_c[k] !== 1'b0) begin
                errors++;
                $display("FAIL %s: inst=%0d pready=%b prdata=%h pslverr=%b evt=%b%b%b, expected all 0",
                         nm, k, pready[k], prdata[k], pslverr[k], evt_a[k], evt_b[k], evt_c[k]);
            end
        end
    endtask

    task automatic check_pulses(input string nm);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (pa[k] != epa[k] || pb[k] != epb[k] || pc[k] != epc[k]) begin
                errors++;
                $display("FAIL %s pulses: inst=%0d a/b/c=%0d/%0d/%0d, expected %0d/%0d/%0d",
                         nm, k, pa[k], pb[k], pc[k], epa[k], epb[k], epc[k]);
            end
        end
    endtask

    task automatic test_reset();
        model_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst = 1'b1;
        @(negedge clk);
        check_quiet("after_reset");
    endtask

    task automatic test_wait1_write();
        xfer(0, A_EVT_A, 1'b1, 32'hDEAD_CAFE, "w1_write_a");
        checks++;
        if (evt_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL w1_evt_early: evt_a=%b, expected 0", evt_a[0]);
        end
        idle();
        checks++;
        if (evt_a[0] !== 1'b1) begin
            errors++;
            $display("FAIL w1_evt_pulse: evt_a=%b, expected 1", evt_a[0]);
        end
        @(negedge clk);
        checks++;
        if (evt_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL w1_evt_width: evt_a=%b, expected 0", evt_a[0]);
        end
        xfer(0, A_EVT_A, 1'b0, 32'd0, "w1_read_a");
        xfer(0, A_CNT, 1'b0, 32'd0, "w1_read_cnt");
        idle();
    endtask

    task automatic test_back_to_back();
        xfer(1, A_EVT_B, 1'b1, 32'h0000_BBBB, "b2b_write_b");
        xfer(1, A_EVT_C, 1'b1, 32'h0000_CCCC, "b2b_write_c");
        xfer(1, A_CNT, 1'b0, 32'd0, "b2b_read_cnt");
        xfer(1, A_EVT_B, 1'b0, 32'd0, "b2b_read_b");
        xfer(1, A_EVT_C, 1'b0, 32'd0, "b2b_read_c");
        idle();
        @(negedge clk);
        check_pulses("b2b");
    endtask

    task automatic test_error();
        xfer(1, A_BAD, 1'b1, 32'h1234_5678, "err_write");
        xfer(1, A_BAD, 1'b0, 32'd0, "err_read");
        xfer(1, A_CNT, 1'b0, 32'd0, "err_cnt_unchanged");
        xfer(1, A_EVT_B, 1'b0, 32'd0, "err_b_unchanged");
        idle();
        @(negedge clk);
        check_pulses("err");
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) xfer(1, A_EVT_A, 1'b1, 32'(i), "sat_write");
        xfer(1, A_CNT, 1'b0, 32'd0, "sat_cnt_ff");
        xfer(1, A_CNT, 1'b1, 32'h0, "sat_clear");
        xfer(1, A_CNT, 1'b0, 32'd0, "sat_cnt_zero");
        xfer(1, A_EVT_A, 1'b0, 32'd0, "sat_last_a");
        idle();
        @(negedge clk);
        check_pulses("sat");
    endtask

    task automatic test_abort_and_reset();
        // psel dropped during WAIT
        @(negedge clk);
        psel = 3'b100; penable = 1'b0; paddr = A_EVT_A; pwrite = 1'b1; pwdata = 32'hBAD0_0001;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel = 3'b000; penable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (pready[2] !== 1'b0 || evt_a[2] !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet: pready=%b evt_a=%b, expected 0/0", pready[2], evt_a[2]);
            end
        end
        xfer(2, A_EVT_A, 1'b0, 32'd0, "abort_a_unchanged");
        idle();
        // reset in the middle of a write
        @(negedge clk);
        psel = 3'b100; penable = 1'b0; paddr = A_EVT_A; pwrite = 1'b1; pwdata = 32'hBAD0_0002;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_quiet("rst_mid");
        @(negedge clk);
        psel = 3'b000; penable = 1'b0;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check_quiet("rst_release");
        xfer(2, A_EVT_A, 1'b0, 32'd0, "rst_a_zero");
        xfer(2, A_CNT, 1'b0, 32'd0, "rst_cnt_zero");
        idle();
        xfer(0, A_EVT_A, 1'b0, 32'd0, "rst_w1_a_zero");
        idle();
        @(negedge clk);
        check_pulses("abort_rst");
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            epa[k] = 0; epb[k] = 0; epc[k] = 0;
            pa[k] = 0; pb[k] = 0; pc[k] = 0;
        end
        test_reset();
        test_wait1_write();
        test_back_to_back();
        test_error();
        test_saturation();
        test_abort_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
